// File: rtl/vector_iterative_divider.sv
// Iterative lane-parallel integer divider: SEW-selectable lanes, restoring division
// one quotient bit per lane per cycle, RISC-V style signed/zero/overflow semantics.
module vector_iterative_divider #(
  parameter int unsigned VLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [1:0]      sew,
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vs1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] vd
);

  localparam int unsigned NL = VLEN / 8;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      op_q, sew_q;
  logic [VLEN-1:0] vs2_q, vs1_q;
  logic [6:0]      cnt;
  logic [VLEN-1:0] res;
  logic            is_signed;

  // Lane storage is sized for the narrowest element; wider SEW uses the low lanes.
  logic [63:0] quo    [NL];
  logic [63:0] rem    [NL];
  logic [63:0] dvs    [NL];
  logic [63:0] quo_nx [NL];
  logic [63:0] rem_nx [NL];

  function automatic int unsigned width(input logic [1:0] s);
    return 8 << s;
  endfunction

  function automatic logic [63:0] mask(input logic [1:0] s);
    case (s)
      2'b00:   return 64'h0000_0000_0000_00ff;
      2'b01:   return 64'h0000_0000_0000_ffff;
      2'b10:   return 64'h0000_0000_ffff_ffff;
      default: return '1;
    endcase
  endfunction

  function automatic logic msb(input logic [63:0] e, input logic [1:0] s);
    case (s)
      2'b00:   return e[7];
      2'b01:   return e[15];
      2'b10:   return e[31];
      default: return e[63];
    endcase
  endfunction

  function automatic logic [63:0] elem(input logic [VLEN-1:0] v, input int unsigned i,
                                       input logic [1:0] s);
    logic [VLEN-1:0] t;
    t = v >> (i * width(s));
    return t[63:0] & mask(s);
  endfunction

  function automatic logic [63:0] neg(input logic [63:0] e, input logic [1:0] s);
    return (~e + 64'd1) & mask(s);
  endfunction

  function automatic logic [63:0] mag(input logic [63:0] e, input logic [1:0] s);
    return msb(e, s) ? neg(e, s) : e;
  endfunction

  // One restoring step: the dividend shifts out of the quotient register MSB-first
  // while quotient bits shift in at the bottom.
  function automatic logic [127:0] step(input logic [63:0] r, input logic [63:0] q,
                                        input logic [63:0] d, input logic [1:0] s);
    logic [64:0] t;
    logic [63:0] r_n, q_n;
    logic        bit_q;
    t = {r, msb(q, s)};
    bit_q = (t >= {1'b0, d});
    r_n = bit_q ? 64'(t - {1'b0, d}) : t[63:0];
    q_n = ((q << 1) | {63'd0, bit_q}) & mask(s);
    return {r_n, q_n};
  endfunction

  function automatic logic [63:0] fix(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] q, input logic [63:0] r,
                                      input logic [1:0] o, input logic [1:0] s);
    logic        sgn;
    logic [63:0] minv, qq, rr;
    sgn  = ~o[0];
    minv = mask(s) ^ (mask(s) >> 1);
    if (b == '0) begin
      qq = mask(s);
      rr = a;
    end else if (sgn && a == minv && b == mask(s)) begin
      qq = a;
      rr = '0;
    end else begin
      qq = (sgn && (msb(a, s) ^ msb(b, s))) ? neg(q, s) : q;
      rr = (sgn && msb(a, s)) ? neg(r, s) : r;
    end
    return o[1] ? rr : qq;
  endfunction

  assign is_signed = ~op_q[0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = PREP;
      PREP:    state_nx = ITER;
      ITER:    if (cnt == 7'd1) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NL; i++) begin
      {rem_nx[i], quo_nx[i]} = step(rem[i], quo[i], dvs[i], sew_q);
    end
  end

  always_comb begin
    res = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      if (i < VLEN / width(sew_q)) begin
        res = res | (VLEN'(fix(elem(vs2_q, i, sew_q), elem(vs1_q, i, sew_q),
                               quo[i], rem[i], op_q, sew_q)) << (i * width(sew_q)));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      sew_q <= '0;
      vs2_q <= '0;
      vs1_q <= '0;
      cnt   <= '0;
      vd    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q  <= op;
          sew_q <= sew;
          vs2_q <= vs2;
          vs1_q <= vs1;
        end
        PREP:    cnt <= 7'(width(sew_q));
        ITER:    cnt <= cnt - 7'd1;
        FIX:     vd  <= res;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NL; i++) begin
      if (state == PREP) begin
        quo[i] <= is_signed ? mag(elem(vs2_q, i, sew_q), sew_q) : elem(vs2_q, i, sew_q);
        dvs[i] <= is_signed ? mag(elem(vs1_q, i, sew_q), sew_q) : elem(vs1_q, i, sew_q);
        rem[i] <= '0;
      end else if (state == ITER) begin
        quo[i] <= quo_nx[i];
        rem[i] <= rem_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_vector_iterative_divider.sv
// Randomized and directed bench for vector_iterative_divider at VLEN=128,
// checked against a plain-arithmetic per-element reference model.
module tb_vector_iterative_divider;

  localparam int unsigned VL = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = '0;
  logic [1:0]    sew = '0;
  logic [VL-1:0] vs2 = '0;
  logic [VL-1:0] vs1 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VL-1:0] vd;

  int checks = 0;
  int errors = 0;

  vector_iterative_divider #(.VLEN(VL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sew(sew), .vs2(vs2), .vs1(vs1),
    .out_valid(out_valid), .out_ready(out_ready), .vd(vd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VL-1:0] got, input logic [VL-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_elem(input logic [1:0] o, input int unsigned w,
                                           input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, a, b, q, r;
    longint sa, sb;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & m;
    b = b_in & m;
    if (b == 0) begin
      q = m;
      r = a;
    end else if (!o[0]) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      if (a == (64'd1 << (w - 1)) && sb == -1) begin
        q = a;
        r = 0;
      end else begin
        q = 64'(sa / sb);
        r = 64'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return (o[1] ? r : q) & m;
  endfunction

  function automatic logic [VL-1:0] ref_vec(input logic [1:0] o, input logic [1:0] s,
                                            input logic [VL-1:0] a, input logic [VL-1:0] b);
    int unsigned w;
    logic [VL-1:0] r;
    w = 8 << s;
    r = '0;
    for (int unsigned i = 0; i < VL / w; i++)
      r = r | (VL'(ref_elem(o, w, 64'(a >> (i * w)), 64'(b >> (i * w)))) << (i * w));
    return r;
  endfunction

  // Issue one request and wait for out_valid; the result is left pending in DONE.
  task automatic issue(input logic [1:0] o, input logic [1:0] s,
                       input logic [VL-1:0] a, input logic [VL-1:0] b,
                       output logic [VL-1:0] res);
    int unsigned n;
    in_valid = 1'b1; op = o; sew = s; vs2 = a; vs1 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; sew = ~s; vs2 = ~a; vs1 = ~b;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid_timeout", VL'(out_valid), VL'(1));
    check("latency", VL'(n), VL'((8 << s) + 2));
    check("vd_model", vd, ref_vec(o, s, a, b));
    res = vd;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", VL'(out_valid), VL'(0));
    check("in_ready_back", VL'(in_ready), VL'(1));
  endtask

  logic [VL-1:0] r, held, a, b, lm;
  int unsigned   w, pick;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", VL'(out_valid), VL'(0));
    check("rst_vd", vd, '0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", VL'(in_ready), VL'(1));

    // 64-bit unsigned
    issue(2'b01, 2'b11, VL'(100), VL'(7), r);
    check("divu64_lane0", VL'(r[63:0]), VL'(14));
    release_result();
    issue(2'b11, 2'b11, VL'(100), VL'(7), r);
    check("remu64_lane0", VL'(r[63:0]), VL'(2));
    release_result();

    // 8-bit signed, overflow lane and negative lane
    issue(2'b00, 2'b00, VL'(16'hF980), VL'(16'h02FF), r);
    check("div8_lanes", VL'(r[15:0]), VL'(16'hFD80));
    release_result();
    issue(2'b10, 2'b00, VL'(16'hF980), VL'(16'h02FF), r);
    check("rem8_lanes", VL'(r[15:0]), VL'(16'hFF00));
    release_result();

    // Divide by zero, 32-bit
    issue(2'b01, 2'b10, VL'(64'h00000005_00000009), '0, r);
    check("divu0", VL'(r[63:0]), VL'(64'hFFFFFFFF_FFFFFFFF));
    release_result();
    issue(2'b11, 2'b10, VL'(64'h00000005_00000009), '0, r);
    check("remu0", r, VL'(64'h00000005_00000009));
    release_result();

    // Backpressure with an ignored in_valid pulse
    issue(2'b00, 2'b01, {4{32'h8001_7fff}}, {4{32'h0003_fff9}}, held);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      @(posedge clk); #1;
      check("bp_vd_stable", vd, held);
      check("bp_in_ready", VL'(in_ready), VL'(0));
      check("bp_out_valid", VL'(out_valid), VL'(1));
    end
    in_valid = 1'b0;
    release_result();
    repeat (3) @(posedge clk);
    #1;
    check("bp_not_queued", VL'(out_valid), VL'(0));

    // Reset mid-ITER
    in_valid = 1'b1; op = 2'b01; sew = 2'b11; vs2 = '1; vs1 = VL'(3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", VL'(out_valid), VL'(0));
    check("midrst_vd", vd, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", VL'(in_ready), VL'(1));
    issue(2'b00, 2'b10, {32'hFFFF_FFF9, 32'd45, 32'h8000_0000, 32'd7},
                        {32'd2, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd0}, r);
    release_result();

    // Random regression
    for (int t = 0; t < 1000; t++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      sew = 2'($urandom_range(0, 3));
      op  = 2'($urandom_range(0, 3));
      w = 8 << sew;
      for (int unsigned i = 0; i < VL / w; i++) begin
        lm = (w == 64) ? VL'(64'hFFFFFFFF_FFFFFFFF) : ((VL'(1) << w) - VL'(1));
        lm = lm << (i * w);
        pick = $urandom_range(0, 99);
        if (pick < 5) begin
          b = b & ~lm;
        end else if (pick < 10) begin
          a = (a & ~lm) | (VL'(1) << (i * w + w - 1));
          b = b | lm;
        end
      end
      issue(op, sew, a, b, r);
      release_result();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_iterative_divider.md
VECTOR_ITERATIVE_DIVIDER -- requirements
Module: vector_iterative_divider

Interface
REQ-001 The block SHALL have parameter VLEN, default 64, giving datapath width in bits; legal values are multiples of 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port op, input, 2 bits: 00 div, 01 divu, 10 rem, 11 remu.
REQ-007 The block SHALL have port sew, input, 2 bits: element width; 00=8, 01=16, 10=32, 11=64.
REQ-008 The block SHALL have port vs2, input, VLEN bits: dividend vector.
REQ-009 The block SHALL have port vs1, input, VLEN bits: divisor vector.
REQ-010 The block SHALL have port out_valid, output, 1 bit: vd holds a finished result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 The block SHALL have port vd, output, VLEN bits: result vector.

Function
REQ-013 The block SHALL split the datapath into VLEN/SEW lanes; lane i occupies bits [i*SEW +: SEW] of vs2, vs1 and vd; lanes are fully independent.
REQ-014 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; op, sew, vs2 and vs1 are registered at acceptance; later input changes are ignored.
REQ-015 The FSM SHALL have states IDLE, PREP, ITER, FIX and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-016 The FSM SHALL move IDLE->PREP on acceptance.
REQ-017 In PREP the block SHALL take per-lane magnitudes for signed ops (div, rem) and load the iteration counter with SEW.
REQ-018 In ITER the block SHALL produce one restoring-division quotient bit per lane per cycle, decrement the counter, and stay for exactly SEW cycles before moving to FIX.
REQ-019 In FIX the block SHALL apply sign correction and special cases, register vd, and move to DONE.
REQ-020 Latency SHALL be SEW+2 cycles: with acceptance at edge N, out_valid rises after edge N+SEW+2.
REQ-021 In DONE, vd and out_valid SHALL stay stable until out_valid and out_ready are both 1; the FSM then moves to IDLE and out_valid drops on that edge.
REQ-022 in_valid asserted outside IDLE SHALL be ignored, not queued; out_ready asserted while out_valid=0 SHALL be ignored.
REQ-023 For signed ops, the quotient sign SHALL be sign(vs2) XOR sign(vs1), and the remainder sign SHALL equal the dividend sign (truncating division).
REQ-024 Division by zero in a lane SHALL give quotient all-ones and remainder equal to the dividend, for both signed and unsigned ops.
REQ-025 Signed overflow in a lane (most-negative / -1) SHALL give quotient equal to the dividend and remainder 0.
REQ-026 div and divu SHALL write quotients to vd; rem and remu SHALL write remainders to vd.

Reset
REQ-027 While rst=1, regardless of clk, the block SHALL be in IDLE with out_valid=0, vd=0 and counter=0; in_ready=1 once rst is released.
REQ-028 Reset asserted in any state, including mid-ITER or DONE, SHALL abandon the operation with no partial result on vd.

Verification
REQ-029 Basic unsigned, 64-bit: VLEN=64, sew=11, op=divu, vs2=100, vs1=7 -> vd=14, with out_valid exactly 66 cycles after acceptance; repeat with op=remu -> vd=2.
REQ-030 Signed, 8-bit: sew=00, op=div, lane0 0x80/0xFF -> 0x80, lane1 0xF9/0x02 -> 0xFD; with op=rem, lane1 -> 0xFF and lane0 -> 0x00; latency 10 cycles.
REQ-031 Divide by zero: sew=10, op=divu, vs2=0x00000005_00000009, vs1=0 -> vd=0xFFFFFFFF_FFFFFFFF; with op=remu -> vd=vs2.
REQ-032 Backpressure: out_ready held 0 for 5 cycles in DONE -> vd stable, in_ready=0, and an in_valid pulse is ignored; out_ready=1 -> IDLE on the next edge.
REQ-033 Reset mid-ITER: rst pulsed during ITER -> out_valid=0 and vd=0 immediately, in_ready=1 after release, and the next request completes correctly.
REQ-034 Random regression: VLEN=128, all sew/op combinations, 1000 requests, with ~5% zero divisors and forced min/-1 lanes -> vd matches a golden model implementing REQ-023 to REQ-026.
